// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster timing outputs shared by the timing generator and pixel renderer
interface vga_timing_if;
    logic        pix_en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic        hSync;
    logic        vSync;
    logic        line_tick;
    logic        frame_tick;
    logic [15:0] frame_count;

    modport master (
        output pix_en, hCount, vCount, bright, hSync, vSync,
               line_tick, frame_tick, frame_count
    );

    modport slave (
        input  pix_en, hCount, vCount, bright, hSync, vSync,
               line_tick, frame_tick, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with pixel-clock enable, line/frame pulses and frame counter
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] V_TICK   = 11'(V_VISIBLE - 1);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             pix_en;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_wrap;
    logic             v_wrap;
    logic             bright_next;
    logic             hs_act;
    logic             vs_act;
    logic             bright_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             line_q;
    logic             frame_q;
    logic [15:0]      frame_cnt;

    assign pix_en = (div == DIV_LAST) & ~rst;

    // Decode from the next position so the registered flags line up with the counters.
    always_comb begin
        h_wrap      = ({1'b0, h_cnt} == H_LAST);
        v_wrap      = ({1'b0, v_cnt} == V_LAST);
        h_next      = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_next      = v_cnt;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : v_cnt + 10'd1;
        end
        bright_next = ({1'b0, h_next} < H_VIS) && ({1'b0, v_next} < V_VIS);
        hs_act      = ({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END);
        vs_act      = ({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            bright_q  <= 1'b0;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            div     <= (div == DIV_LAST) ? '0 : div + 1'b1;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            if (pix_en) begin
                h_cnt    <= h_next;
                v_cnt    <= v_next;
                bright_q <= bright_next;
                hsync_q  <= hs_act ? SYNC_POL : ~SYNC_POL;
                vsync_q  <= vs_act ? SYNC_POL : ~SYNC_POL;
                line_q   <= h_wrap;
                // Start of vertical blank: last visible line is wrapping.
                if (h_wrap && ({1'b0, v_cnt} == V_TICK)) begin
                    frame_q   <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

    assign vga.pix_en      = pix_en;
    assign vga.hCount      = h_cnt;
    assign vga.vCount      = v_cnt;
    assign vga.bright      = bright_q;
    assign vga.hSync       = hsync_q;
    assign vga.vSync       = vsync_q;
    assign vga.line_tick   = line_q;
    assign vga.frame_tick  = frame_q;
    assign vga.frame_count = frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen on a reduced 16x11 raster with 2 clks per pixel
module tb_vga_timing_gen;
    localparam int D   = 2;
    localparam int HV  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VV  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        pe;
        logic        br;
        logic        hs;
        logic        vs;
        logic        lt;
        logic        ft;
        logic [15:0] fc;
    } outs_t;

    typedef struct {
        int    clks;
        bit    rst_val;
        outs_t exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   k;
    outs_t sb_q[$];

    vga_timing_if vga();

    vga_timing_gen #(
        .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(vga)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t mk(int h, int v, bit pe, bit br, bit hs, bit vs, bit lt, bit ft, int fc);
        outs_t o;
        o.h  = 10'(h);
        o.v  = 10'(v);
        o.pe = pe;
        o.br = br;
        o.hs = hs;
        o.vs = vs;
        o.lt = lt;
        o.ft = ft;
        o.fc = 16'(fc);
        return o;
    endfunction

    // Closed-form expectation from the number of clocks since reset was released.
    function automatic outs_t model(int kk, bit r);
        int s, h, v, fc;
        bit lt;
        s  = kk / D;
        h  = s % HT;
        v  = (s / HT) % VT;
        lt = (s > 0) && (kk % D == 0) && (h == 0);
        fc = (s >= VV * HT) ? (s - VV * HT) / (VT * HT) + 1 : 0;
        return mk(h, v, !r && (kk % D == D - 1), (s > 0) && (h < HV) && (v < VV),
                  !((h >= HV + HFP) && (h < HV + HFP + HS)),
                  !((v >= VV + VFP) && (v < VV + VFP + VS)),
                  lt, lt && (v == VV), fc);
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("h=%0d v=%0d pe=%0b br=%0b hs=%0b vs=%0b lt=%0b ft=%0b fc=%0d",
                         o.h, o.v, o.pe, o.br, o.hs, o.vs, o.lt, o.ft, o.fc);
    endfunction

    function automatic outs_t sample();
        return {vga.hCount, vga.vCount, vga.pix_en, vga.bright, vga.hSync, vga.vSync,
                vga.line_tick, vga.frame_tick, vga.frame_count};
    endfunction

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        sb_q.push_back(model(rst ? 0 : k + 1, rst));
        k <= rst ? 0 : k + 1;
    end

    always @(negedge clk) begin
        outs_t act;
        outs_t exp;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty at %0t", $time);
        end else begin
            exp = sb_q.pop_front();
            act = sample();
            if (act !== exp) begin
                errors++;
                $display("FAIL sb t=%0t got %s expected %s", $time, fmt(act), fmt(exp));
            end
        end
    end

    initial begin
        vec_t  vecs[18];
        outs_t act;
        int    cyc, ticks, t_prev, nb, nh, nv;

        checks = 0;
        errors = 0;
        k      = 0;
        rst    = 1'b1;

        vecs[0]  = '{3,   1'b1, mk(0, 0, 0, 0, 1, 1, 0, 0, 0)};
        vecs[1]  = '{1,   1'b0, mk(0, 0, 1, 0, 1, 1, 0, 0, 0)};
        vecs[2]  = '{1,   1'b0, mk(1, 0, 0, 1, 1, 1, 0, 0, 0)};
        vecs[3]  = '{18,  1'b0, mk(10, 0, 0, 0, 0, 1, 0, 0, 0)};
        vecs[4]  = '{5,   1'b0, mk(12, 0, 1, 0, 0, 1, 0, 0, 0)};
        vecs[5]  = '{1,   1'b0, mk(13, 0, 0, 0, 1, 1, 0, 0, 0)};
        vecs[6]  = '{6,   1'b0, mk(0, 1, 0, 1, 1, 1, 1, 0, 0)};
        vecs[7]  = '{1,   1'b0, mk(0, 1, 1, 1, 1, 1, 0, 0, 0)};
        vecs[8]  = '{159, 1'b0, mk(0, 6, 0, 0, 1, 1, 1, 1, 1)};
        vecs[9]  = '{1,   1'b0, mk(0, 6, 1, 0, 1, 1, 0, 0, 1)};
        vecs[10] = '{31,  1'b0, mk(0, 7, 0, 0, 1, 0, 1, 0, 1)};
        vecs[11] = '{64,  1'b0, mk(0, 9, 0, 0, 1, 1, 1, 0, 1)};
        vecs[12] = '{64,  1'b0, mk(0, 0, 0, 1, 1, 1, 1, 0, 1)};
        vecs[13] = '{1,   1'b0, mk(0, 0, 1, 1, 1, 1, 0, 0, 1)};
        vecs[14] = '{105, 1'b0, mk(5, 3, 0, 1, 1, 1, 0, 0, 1)};
        vecs[15] = '{1,   1'b1, mk(0, 0, 0, 0, 1, 1, 0, 0, 0)};
        vecs[16] = '{1,   1'b0, mk(0, 0, 1, 0, 1, 1, 0, 0, 0)};
        vecs[17] = '{1,   1'b0, mk(1, 0, 0, 1, 1, 1, 0, 0, 0)};

        for (int i = 0; i < 18; i++) begin
            #1 rst = vecs[i].rst_val;
            repeat (vecs[i].clks) @(negedge clk);
            act = sample();
            checks++;
            if (act !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d got %s expected %s", i, fmt(act), fmt(vecs[i].exp));
            end
        end

        // Frame pacing over two complete frames after the first vblank tick.
        cyc = 0; ticks = 0; t_prev = 0; nb = 0; nh = 0; nv = 0;
        while (ticks < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (ticks >= 1) begin
                nb += int'(vga.bright && vga.pix_en);
                nh += int'(!vga.hSync);
                nv += int'(!vga.vSync);
            end
            if (vga.frame_tick) begin
                ticks++;
                if (ticks > 1) check_int("frame_period", cyc - t_prev, HT * VT * D);
                t_prev = cyc;
                if (ticks == 3) check_int("frame_count", int'(vga.frame_count), 3);
            end
        end
        check_int("frame_ticks_seen", ticks, 3);
        check_int("bright_pixels", nb, 2 * HV * VV);
        check_int("hsync_low_clks", nh, 2 * HS * D * VT);
        check_int("vsync_low_clks", nv, 2 * VS * HT * D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
